layer_out_serializer: RTL and testbench

Converts the parallel output of one fully-connected layer (NN neuron results, each DATA_WIDTH bits, with per-neuron valids) into a serial stream, one neuron value per beat. It sits between two layer instances in the network top, and feeds the next layer's broadcast x_in/x_valid inputs. It adds downstream backpressure, exact beat counting, last-beat marking and overrun detection.

---
 rtl/layer_out_serializer.sv | 93 +++++++++
 tb/tb_layer_out_serializer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_out_serializer.sv
// Serializes one layer's parallel neuron outputs into a ready/valid beat stream,
// neuron 0 first, with last-beat marking, frame counting and sticky overrun.
module layer_out_serializer #(
  parameter int NN         = 30,
  parameter int DATA_WIDTH = 16,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NN-1:0]              i_valid,
  input  logic [NN*DATA_WIDTH-1:0]   i_data,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_valid,
  output logic                       o_last,
  input  logic                       i_ready,
  output logic                       o_busy,
  output logic                       o_overrun,
  input  logic                       i_clr_overrun,
  output logic [FCNT_WIDTH-1:0]      o_frame_count
);

  // state | meaning
  // IDLE  | no frame held, waiting for an all-valid vector
  // SEND  | presenting hold[index] on o_data
  typedef enum logic {IDLE, SEND} state_t;

  localparam int IW = $clog2(NN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  state_t state, state_nxt;
  logic [IW-1:0] index;
  logic [DATA_WIDTH-1:0] hold [NN];

  logic cap, in_send, accept, is_last, last_acc, load, ovr_set;

  assign cap      = &i_valid;
  assign in_send  = (state == SEND);
  assign accept   = in_send && i_ready;
  assign is_last  = (index == LAST_IDX);
  assign last_acc = accept && is_last;
  // A new frame is taken only when nothing is held or the held one just finished.
  assign load     = cap && (!in_send || last_acc);
  assign ovr_set  = cap && in_send && !last_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cap) state_nxt = SEND;
      SEND: if (last_acc && !cap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_valid = in_send;
    o_busy  = in_send;
    o_last  = in_send && is_last;
    o_data  = in_send ? hold[index] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index         <= '0;
      o_overrun     <= 1'b0;
      o_frame_count <= '0;
    end else begin
      if (load)
        index <= '0;
      else if (accept && !is_last)
        index <= index + IW'(1);

      if (last_acc)
        o_frame_count <= o_frame_count + FCNT_WIDTH'(1);

      if (ovr_set)
        o_overrun <= 1'b1;
      else if (i_clr_overrun)
        o_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load)
      for (int k = 0; k < NN; k++)
        hold[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer: NN=4 instance for the detailed
// scenarios and a default NN=30 instance for full-length framing.
module tb_layer_out_serializer;
  localparam int DW = 16;
  localparam logic [4*DW-1:0] FRAME_A = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
  localparam logic [4*DW-1:0] FRAME_B = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
  localparam int STALL_WORD [6] = '{1, 2, 2, 3, 3, 4};
  localparam bit STALL_RDY  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]      v4;
  logic [4*DW-1:0] d4;
  logic            rdy4, clr4;
  logic [DW-1:0]   o_data4;
  logic            o_valid4, o_last4, o_busy4, o_overrun4;
  logic [15:0]     fc4;

  logic [29:0]      v30;
  logic [30*DW-1:0] d30;
  logic             rdy30, clr30;
  logic [DW-1:0]    o_data30;
  logic             o_valid30, o_last30, o_busy30, o_overrun30;
  logic [15:0]      fc30;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_fc4;

  layer_out_serializer #(.NN(4), .DATA_WIDTH(DW), .FCNT_WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .i_valid(v4), .i_data(d4), .o_data(o_data4),
    .o_valid(o_valid4), .o_last(o_last4), .i_ready(rdy4), .o_busy(o_busy4),
    .o_overrun(o_overrun4), .i_clr_overrun(clr4), .o_frame_count(fc4));

  layer_out_serializer dut30 (
    .clk(clk), .rst(rst), .i_valid(v30), .i_data(d30), .o_data(o_data30),
    .o_valid(o_valid30), .o_last(o_last30), .i_ready(rdy30), .o_busy(o_busy30),
    .o_overrun(o_overrun30), .i_clr_overrun(clr30), .o_frame_count(fc30));

  task automatic test_reset();
    rst = 1'b1; v4 = '0; d4 = '0; rdy4 = 1'b1; clr4 = 1'b0;
    v30 = '0; d30 = '0; rdy30 = 1'b1; clr30 = 1'b0;
    exp_fc4 = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({o_valid4, o_last4, o_busy4, o_overrun4} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags4: got %b want 0000", {o_valid4, o_last4, o_busy4, o_overrun4});
    end
    vectors++;
    if ({o_data4, fc4} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data_fc4: got %h want 00000000", {o_data4, fc4});
    end
    vectors++;
    if ({o_valid30, o_busy30, o_overrun30, fc30} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_dut30: got %h want 0", {o_valid30, o_busy30, o_overrun30, fc30});
    end
    rst = 1'b0;
  endtask

  task automatic test_partial();
    @(negedge clk);
    v4 = 4'b0111; d4 = FRAME_B;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if (o_valid4 !== 1'b0) begin
        miscompares++;
        $display("FAIL partial_valid cycle %0d: got %b want 0", k, o_valid4);
      end
    end
    v4 = '0;
    vectors++;
    if (fc4 !== exp_fc4) begin
      miscompares++;
      $display("FAIL partial_fc: got %0d want %0d", fc4, exp_fc4);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    v4 = 4'hF; d4 = FRAME_A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v4 = '0; d4 = FRAME_B;
      vectors++;
      if ({o_valid4, o_busy4, o_last4, o_data4} !== {1'b1, 1'b1, (k == 3), 16'(k + 1)}) begin
        miscompares++;
        $display("FAIL single_beat %0d: got v=%b b=%b l=%b d=%h want v=1 b=1 l=%b d=%h",
                 k, o_valid4, o_busy4, o_last4, o_data4, (k == 3), 16'(k + 1));
      end
    end
    @(negedge clk);
    exp_fc4 = exp_fc4 + 16'd1;
    vectors++;
    if ({o_valid4, o_busy4, fc4} !== {2'b00, exp_fc4}) begin
      miscompares++;
      $display("FAIL single_end: got v=%b b=%b fc=%0d want v=0 b=0 fc=%0d", o_valid4, o_busy4, fc4, exp_fc4);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    v4 = 4'hF; d4 = FRAME_A;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      v4 = '0;
      vectors++;
      if ({o_valid4, o_last4, o_data4} !== {1'b1, (k == 5), 16'(STALL_WORD[k])}) begin
        miscompares++;
        $display("FAIL stall_cycle %0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                 k, o_valid4, o_last4, o_data4, (k == 5), 16'(STALL_WORD[k]));
      end
      rdy4 = STALL_RDY[k];
    end
    @(negedge clk);
    rdy4 = 1'b1;
    exp_fc4 = exp_fc4 + 16'd1;
    vectors++;
    if ({o_valid4, fc4} !== {1'b0, exp_fc4}) begin
      miscompares++;
      $display("FAIL stall_end: got v=%b fc=%0d want v=0 fc=%0d", o_valid4, fc4, exp_fc4);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    v4 = 4'hF; d4 = FRAME_A;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vectors++;
      if ({o_valid4, o_last4, o_data4} !== {1'b1, (k == 3 || k == 7), 16'(k + 1)}) begin
        miscompares++;
        $display("FAIL b2b_beat %0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                 k, o_valid4, o_last4, o_data4, (k == 3 || k == 7), 16'(k + 1));
      end
      v4 = (k == 3) ? 4'hF : 4'h0;
      d4 = (k == 3) ? FRAME_B : '0;
    end
    @(negedge clk);
    exp_fc4 = exp_fc4 + 16'd2;
    vectors++;
    if ({o_valid4, o_overrun4, fc4} !== {2'b00, exp_fc4}) begin
      miscompares++;
      $display("FAIL b2b_end: got v=%b ovr=%b fc=%0d want v=0 ovr=0 fc=%0d", o_valid4, o_overrun4, fc4, exp_fc4);
    end
  endtask

  task automatic test_overrun();
    @(negedge clk);
    v4 = 4'hF; d4 = FRAME_A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({o_valid4, o_data4} !== {1'b1, 16'(k + 1)}) begin
        miscompares++;
        $display("FAIL ovr_beat %0d: got v=%b d=%h want v=1 d=%h", k, o_valid4, o_data4, 16'(k + 1));
      end
      v4 = (k == 1) ? 4'hF : 4'h0;
      d4 = FRAME_B;
    end
    @(negedge clk);
    exp_fc4 = exp_fc4 + 16'd1;
    vectors++;
    if ({o_valid4, o_overrun4, fc4} !== {2'b01, exp_fc4}) begin
      miscompares++;
      $display("FAIL ovr_set: got v=%b ovr=%b fc=%0d want v=0 ovr=1 fc=%0d", o_valid4, o_overrun4, fc4, exp_fc4);
    end
    clr4 = 1'b1;
    @(negedge clk);
    clr4 = 1'b0;
    vectors++;
    if (o_overrun4 !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_clear: got %b want 0", o_overrun4);
    end
    v4 = 4'hF; d4 = FRAME_A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (o_data4 !== 16'(k + 1)) begin
        miscompares++;
        $display("FAIL ovr2_beat %0d: got %h want %h", k, o_data4, 16'(k + 1));
      end
      v4 = (k == 1) ? 4'hF : 4'h0;
      clr4 = (k == 1);
    end
    @(negedge clk);
    exp_fc4 = exp_fc4 + 16'd1;
    vectors++;
    if ({o_valid4, o_overrun4, fc4} !== {2'b01, exp_fc4}) begin
      miscompares++;
      $display("FAIL ovr_set_wins: got v=%b ovr=%b fc=%0d want v=0 ovr=1 fc=%0d", o_valid4, o_overrun4, fc4, exp_fc4);
    end
    clr4 = 1'b1;
    @(negedge clk);
    clr4 = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    v4 = 4'hF; d4 = FRAME_A;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      v4 = '0;
    end
    vectors++;
    if ({o_valid4, o_data4} !== {1'b1, 16'h0003}) begin
      miscompares++;
      $display("FAIL rstmid_pre: got v=%b d=%h want v=1 d=0003", o_valid4, o_data4);
    end
    rst = 1'b1;
    #1;
    exp_fc4 = '0;
    vectors++;
    if ({o_valid4, o_busy4, fc4} !== {2'b00, exp_fc4}) begin
      miscompares++;
      $display("FAIL rstmid_drop: got v=%b b=%b fc=%0d want v=0 b=0 fc=0", o_valid4, o_busy4, fc4);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    v4 = 4'hF; d4 = FRAME_A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v4 = '0;
      vectors++;
      if ({o_valid4, o_last4, o_data4} !== {1'b1, (k == 3), 16'(k + 1)}) begin
        miscompares++;
        $display("FAIL rstmid_beat %0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                 k, o_valid4, o_last4, o_data4, (k == 3), 16'(k + 1));
      end
    end
    @(negedge clk);
    exp_fc4 = exp_fc4 + 16'd1;
    vectors++;
    if ({o_valid4, fc4} !== {1'b0, exp_fc4}) begin
      miscompares++;
      $display("FAIL rstmid_end: got v=%b fc=%0d want v=0 fc=%0d", o_valid4, fc4, exp_fc4);
    end
  endtask

  task automatic test_nn30();
    int beats;
    int lasts;
    beats = 0; lasts = 0;
    @(negedge clk);
    for (int k = 0; k < 30; k++) d30[k*DW +: DW] = 16'(16'h0100 + k);
    v30 = '1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      v30 = '0;
      if (o_valid30) beats++;
      if (o_last30) lasts++;
      vectors++;
      if ({o_valid30, o_last30, o_data30} !== {1'b1, (k == 29), 16'(16'h0100 + k)}) begin
        miscompares++;
        $display("FAIL nn30_beat %0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                 k, o_valid30, o_last30, o_data30, (k == 29), 16'(16'h0100 + k));
      end
    end
    @(negedge clk);
    if (o_valid30) beats++;
    vectors++;
    if (beats != 30 || lasts != 1) begin
      miscompares++;
      $display("FAIL nn30_count: got beats=%0d lasts=%0d want beats=30 lasts=1", beats, lasts);
    end
    vectors++;
    if ({o_valid30, fc30} !== {1'b0, 16'd1}) begin
      miscompares++;
      $display("FAIL nn30_end: got v=%b fc=%0d want v=0 fc=1", o_valid30, fc30);
    end
  endtask

  initial begin
    test_reset();
    test_partial();
    test_single();
    test_stall();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_nn30();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
